// File: rtl/npc_bp_pkg.sv
// Shared definitions for the branch-predicting next-PC unit.
//   - ctr_t       : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - DEFAULT_*   : default reset PC and exception entry address
//   - sat_update  : one saturating step of a direction counter
package npc_bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_t;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_ISR_ADDRESS = 32'h0000_4180;

    // Move the counter one step towards the resolved direction, sticking at the ends.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/npc_bp_bht.sv
// Branch history table: DEPTH entries of 2-bit saturating direction counters.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset (all entries -> WNT)
//   rd_idx / rd_taken   : combinational lookup, returns counter MSB (predict taken)
//   wr_en / wr_idx /
//   wr_taken            : saturating training of one entry on the rising edge
// A lookup of the entry being trained in the same cycle sees the old value,
// since the read comes straight off the registered array.
module npc_bp_bht
    import npc_bp_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       rd_taken,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic                       wr_taken
);

    localparam int IDX = $clog2(DEPTH);

    logic [1:0] ctr_reg  [DEPTH];
    logic [1:0] ctr_next [DEPTH];

    // Per-entry next value: only the addressed entry moves.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign ctr_next[gi] = (wr_en && (wr_idx == IDX'(gi)))
                                ? sat_update(ctr_reg[gi], wr_taken)
                                : ctr_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_reg[i] <= CTR_WNT;
            end
        end else begin
            ctr_reg <= ctr_next;
        end
    end

    assign rd_taken = ctr_reg[rd_idx][1];

endmodule

// File: rtl/npc_bp.sv
// Branch-predicting next-PC unit. Owns the fetch PC register and chooses the
// next fetch address from exception entry, ERET, EX-stage misprediction
// recovery, stall hold, predicted target or sequential PC (in that priority).
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   stall                        : hold PC (redirects still win)
//   pc                           : registered fetch address
//   f_is_cond/f_is_j/f_offset/
//   f_jnum                       : pre-decode of the instruction at pc
//   pred_taken                   : prediction for the instruction at pc
//   r_*                          : EX-stage resolution of a control instruction
//   exc_req, eret_req, epc       : exception entry / return
//   flush                        : squash younger instructions
//   n_branch, n_mispred          : wrapping performance counters
module npc_bp
    import npc_bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] ISR_ADDRESS = DEFAULT_ISR_ADDRESS,
    parameter int          BHT_DEPTH   = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic [31:0] pc,
    input  logic        f_is_cond,
    input  logic        f_is_j,
    input  logic [15:0] f_offset,
    input  logic [25:0] f_jnum,
    output logic        pred_taken,
    input  logic        r_valid,
    input  logic        r_is_cond,
    input  logic [31:0] r_pc,
    input  logic        r_taken,
    input  logic [31:0] r_target,
    input  logic        r_pred_taken,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic        flush,
    output logic [31:0] n_branch,
    output logic [31:0] n_mispred
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [31:0] pc_reg, pc_next;
    logic [31:0] n_branch_reg, n_mispred_reg;
    logic        bht_taken;
    logic        train;
    logic        mispredict;
    logic [31:0] pc_plus4;
    logic [31:0] cond_target, j_target, pred_target;
    logic [31:0] redirect_pc;

    assign train      = r_valid & r_is_cond;
    assign mispredict = r_valid & (r_taken != r_pred_taken);

    npc_bp_bht #(
        .DEPTH(BHT_DEPTH)
    ) u_bht (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (pc_reg[IDX+1:2]),
        .rd_taken (bht_taken),
        .wr_en    (train),
        .wr_idx   (r_pc[IDX+1:2]),
        .wr_taken (r_taken)
    );

    // Unconditional jumps are always predicted taken; conditionals follow the table.
    assign pred_taken  = f_is_j | (f_is_cond & bht_taken);

    assign pc_plus4    = pc_reg + 32'd4;
    assign cond_target = pc_plus4 + {{14{f_offset[15]}}, f_offset, 2'b00};
    assign j_target    = {pc_reg[31:28], f_jnum, 2'b00};
    assign pred_target = f_is_j ? j_target : cond_target;

    // No delay slot: a not-taken recovery restarts right after the branch.
    assign redirect_pc = r_taken ? r_target : r_pc + 32'd4;

    assign flush = exc_req | eret_req | mispredict;

    always_comb begin
        pc_next = pc_plus4;
        if (exc_req) begin
            pc_next = ISR_ADDRESS;
        end else if (eret_req) begin
            pc_next = epc;
        end else if (mispredict) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg        <= RESET_PC;
            n_branch_reg  <= 32'd0;
            n_mispred_reg <= 32'd0;
        end else begin
            pc_reg <= pc_next;
            if (train) begin
                n_branch_reg <= n_branch_reg + 32'd1;
            end
            if (mispredict) begin
                n_mispred_reg <= n_mispred_reg + 32'd1;
            end
        end
    end

    assign pc        = pc_reg;
    assign n_branch  = n_branch_reg;
    assign n_mispred = n_mispred_reg;

endmodule
